clk_tick_sched: RTL and testbench
=================================

// Module: clk_tick_sched
// PURPOSE
//  Run/step/halt controller and tick scheduler for the multicore processor.
//  Holds a programmable divide ratio and generates one slow tick every DIV clk cycles.
//  Hands each tick as a one-cycle enable to one of N_CORES requesting cores, picked round-robin.
//  Sits between the debug/board controls and the per-core clock-enable inputs.
// PARAMETERS
//  N_CORES      4         number of requesting cores (2..8)
//  CNT_W        32        width of divide ratio and internal counter
//  DEFAULT_DIV  6250000   divide ratio loaded at reset
// PORTS
//  clk         in   1        system clock; all logic on rising edge
//  rst         in   1        asynchronous, active-low reset (0 = reset)
//  cfg_we      in   1        load cfg_div into div register (honoured in IDLE only)
//  cfg_div     in   CNT_W    new divide ratio; 0 is treated as 1
//  run         in   1        level/pulse: start free-running ticks
//  step        in   1        pulse: deliver exactly one granted tick, then stop
//  halt        in   1        pulse: stop immediately, clear counter
//  req         in   N_CORES  per-core tick request, level-sensitive
//  tick_en     out  N_CORES  registered one-hot grant pulse, 1 cycle
//  busy        out  1        high when state != IDLE
//  state       out  2        IDLE=00, RUN=01, STEP=10
//  div_cur     out  CNT_W    current divide ratio
//  tick_count  out  16       granted ticks since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values:
//   state=IDLE, count=0, div=DEFAULT_DIV, rr_ptr=0 (core 0 searched first).
//   tick_en=0, tick_count=0.
//  FSM priority each edge: halt > run > step.
//   IDLE: run -> RUN; else step -> STEP. Entering either state clears count.
//   RUN: halt -> IDLE; run/step ignored.
//   STEP: halt -> IDLE; after the edge that issues a tick -> IDLE.
//   halt in IDLE: no effect beyond count=0.
//  Counter (RUN/STEP only):
//   count increments each cycle, wraps at div-1.
//   Terminal = (count==div-1); effective div = max(cfg_div,1).
//   In IDLE, count holds 0.
//  Grant on terminal cycle:
//   Search req starting at rr_ptr, wrapping at N_CORES-1; first set bit wins.
//   Next edge: tick_en=onehot(winner), rr_ptr=winner+1 mod N, tick_count+1.
//   req==0 at terminal: tick dropped. No pulse, rr_ptr unchanged; STEP stays in STEP.
//  Latency: state enters RUN at edge E -> first tick_en high after edge E+div.
//   Later ticks follow every div cycles.
//  tick_en is zero on every cycle except a grant cycle.
//   A halt on the terminal cycle suppresses that grant.
//  cfg_we outside IDLE: ignored, div unchanged.
//   cfg_we with run on the same IDLE edge: div loads, and the new div applies to the first period.
//  rst asserted mid-operation: everything returns to reset values asynchronously.
//   Any tick_en pulse in flight is cleared.
// TESTING
//  1 Release rst -> state=00, tick_en=0, div_cur=6250000, tick_count=0, busy=0.
//  2 cfg_div=4 in IDLE, run pulse, req=1111 -> tick_en 0001,0010,0100,1000,0001 every 4 cycles.
//  3 div=3, RUN, req=0101 -> grants alternate 0001,0100.
//    Then req=0000 -> no pulses, tick_count frozen.
//  4 div=5, step pulse, req=0010 -> single tick_en=0010 five cycles later, state back to 00.
//    With req=0 during STEP -> remains STEP until req set.
//  5 RUN div=8, halt at count=7 -> no tick_en, state=00, count 0.
//    cfg_we during RUN -> div_cur unchanged.
//  6 cfg_div=0, run, req=0001 -> tick_en=0001 every cycle.
//    Assert rst mid-pulse -> outputs clear immediately.

Source files
------------

// File: rtl/clk_tick_sched.sv
// clk_tick_sched: run/step/halt controller and round-robin tick scheduler.
// A programmable divider produces one slow tick every div cycles while
// running or stepping. Each tick is granted as a one-cycle enable pulse to
// the first requesting core found from a rotating search pointer.
module clk_tick_sched #(
  parameter int N_CORES     = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 6250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               run,
  input  logic               step,
  input  logic               halt,
  input  logic [N_CORES-1:0] req,
  output logic [N_CORES-1:0] tick_en,
  output logic               busy,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   div_cur,
  output logic [15:0]        tick_count
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CORES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_div;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [N_CORES-1:0] r_tick_en;
  logic [15:0]        r_tick_count;

  logic               w_terminal;
  logic               w_grant;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  int                 w_pos;
  logic [N_CORES-1:0] w_onehot;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Terminal cycle of the divider; a halt on that cycle cancels the grant.
  assign w_terminal = (r_state != ST_IDLE) && (r_count == (r_div - ONE));
  assign w_grant    = w_terminal && (|req) && !halt;

  // Round-robin search: first requesting core at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = 0;
    w_idx   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_pos = int'(r_rr_ptr) + i;
      if (w_pos >= N_CORES) w_pos = w_pos - N_CORES;
      w_idx = PTR_W'(w_pos);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // One-hot grant vector and the pointer position just past the winner.
  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
    w_ptr_nxt       = (w_win == PTR_LAST) ? '0 : (w_win + 1'b1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: halt beats run beats step; STEP ends after its granted tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (halt)      w_state_nxt = ST_IDLE;
        else if (run)  w_state_nxt = ST_RUN;
        else if (step) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (halt) w_state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (halt || w_grant) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    state = r_state;
    busy  = (r_state != ST_IDLE);
  end

  // Divide counter: held at 0 in IDLE and on halt, wraps after div-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if ((r_state == ST_IDLE) || halt || w_terminal) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE;
    end
  end

  // Divide ratio register: writable only in IDLE, zero stored as one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= CNT_W'(DEFAULT_DIV);
    end else if ((r_state == ST_IDLE) && cfg_we) begin
      r_div <= (cfg_div == '0) ? ONE : cfg_div;
    end
  end

  // Grant pulse, round-robin pointer and granted-tick counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_en    <= '0;
      r_rr_ptr     <= '0;
      r_tick_count <= '0;
    end else begin
      r_tick_en <= w_grant ? w_onehot : '0;
      if (w_grant) begin
        r_rr_ptr     <= w_ptr_nxt;
        r_tick_count <= r_tick_count + 16'd1;
      end
    end
  end

  assign tick_en    = r_tick_en;
  assign div_cur    = r_div;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_clk_tick_sched.sv
// Testbench for clk_tick_sched: directed scenarios plus randomized control
// traffic, checked against an abstract model through a tick scoreboard.
module tb_clk_tick_sched;

  localparam int N    = 4;
  localparam int CW   = 32;
  localparam int DDIV = 6250000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_div = '0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  tick_en;
  logic          busy;
  logic [1:0]    state;
  logic [CW-1:0] div_cur;
  logic [15:0]   tick_count;

  clk_tick_sched #(.N_CORES(N), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_div(cfg_div),
    .run(run), .step(step), .halt(halt), .req(req),
    .tick_en(tick_en), .busy(busy), .state(state),
    .div_cur(div_cur), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint       cyc;
    logic [N-1:0] oh;
  } exp_t;

  int           n_chk = 0;
  int           n_fail = 0;
  longint       cyc = 0;
  exp_t         q[$];
  logic [N-1:0] seen[$];

  // Abstract model: mode 0 idle, 1 run, 2 step; elapsed cycles since start.
  int           m_mode;
  longint       m_div;
  longint       m_el;
  int           m_ptr;
  logic [15:0]  m_tc;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_div  = DDIV;
    m_el   = 0;
    m_ptr  = 0;
    m_tc   = '0;
    q.delete();
  endtask

  // Apply the current inputs to the model for the coming rising edge.
  task automatic model_edge();
    int           w;
    logic [N-1:0] rv;
    exp_t         e;
    if (m_mode == 0) begin
      if (cfg_we) m_div = (cfg_div == 0) ? 1 : longint'(cfg_div);
      if (!halt) begin
        if (run) begin m_mode = 1; m_el = 0; end
        else if (step) begin m_mode = 2; m_el = 0; end
      end
    end else if (halt) begin
      m_mode = 0;
    end else begin
      if (((m_el + 1) % m_div) == 0 && req != 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          rv = req >> ((m_ptr + k) % N);
          if (w < 0 && rv[0]) w = (m_ptr + k) % N;
        end
        m_tc  = m_tc + 16'd1;
        e.cyc = cyc + 1;
        e.oh  = N'(1 << w);
        q.push_back(e);
        m_ptr = (w + 1) % N;
        if (m_mode == 2) m_mode = 0;
      end
      m_el++;
    end
  endtask

  // One clock: model, edge, then settle to just after the falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic load_div(input int d);
    cfg_we = 1'b1; cfg_div = CW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_run();  run = 1'b1;  tick(); run = 1'b0;  endtask
  task automatic pulse_step(); step = 1'b1; tick(); step = 1'b0; endtask
  task automatic pulse_halt(); halt = 1'b1; tick(); halt = 1'b0; endtask

  // Monitor: per-cycle status checks and tick scoreboard.
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      chk("state", state, m_mode);
      chk("busy", busy, (m_mode != 0));
      chk("div_cur", div_cur, m_div);
      chk("tick_count", tick_count, m_tc);
      if (tick_en != '0) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tick_unexpected: got %b expected none (cycle %0d)", tick_en, cyc);
        end else begin
          me = q.pop_front();
          chk("tick_cycle", cyc, me.cyc);
          chk("tick_en", tick_en, me.oh);
        end
        seen.push_back(tick_en);
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL tick_missing: got 0 expected %b at cycle %0d", q[0].oh, q[0].cyc);
        q.delete(0);
      end
    end
  end

  logic [N-1:0] exp2[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] exp3[4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_tick_en", tick_en, 0);
    chk("rst_div", div_cur, DDIV);
    chk("rst_tick_count", tick_count, 0);
    chk("rst_busy", busy, 0);

    // Divide by 4, all cores requesting: rotate through every core.
    load_div(4);
    req = 4'b1111;
    pulse_run();
    seen.delete();
    repeat (20) tick();
    chk("t2_npulses", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("t2_seq", seen[i], exp2[i]);
    pulse_halt();

    // Divide by 3, two cores requesting alternate; then no requests.
    load_div(3);
    req = 4'b0101;
    pulse_run();
    seen.delete();
    repeat (12) tick();
    chk("t3_npulses", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t3_seq", seen[i], exp3[i]);
    req = 4'b0000;
    seen.delete();
    repeat (9) tick();
    chk("t3_no_pulse", seen.size(), 0);
    chk("t3_tc_frozen", tick_count, 9);
    pulse_halt();

    // Step with a request: one tick five cycles later, then idle.
    load_div(5);
    req = 4'b0010;
    pulse_step();
    seen.delete();
    repeat (7) tick();
    chk("t4_npulses", seen.size(), 1);
    if (seen.size() > 0) chk("t4_grant", seen[0], 4'b0010);
    chk("t4_idle", state, 2'b00);
    req = 4'b0000;
    pulse_step();
    repeat (12) tick();
    chk("t4_step_wait", state, 2'b10);
    req = 4'b0010;
    seen.delete();
    repeat (5) tick();
    chk("t4_step_done", state, 2'b00);
    chk("t4_npulses2", seen.size(), 1);

    // Divide by 8, cfg write during RUN ignored, halt on terminal cycle.
    load_div(8);
    req = 4'b1111;
    pulse_run();
    seen.delete();
    tick();
    cfg_we = 1'b1; cfg_div = 2;
    tick();
    cfg_we = 1'b0;
    repeat (5) tick();
    chk("t5_div_kept", div_cur, 8);
    pulse_halt();
    repeat (3) tick();
    chk("t5_no_pulse", seen.size(), 0);
    chk("t5_idle", state, 2'b00);
    pulse_run();
    repeat (8) tick();
    chk("t5_restart_pulses", seen.size(), 1);
    pulse_halt();

    // Divide ratio 0 behaves as 1: a tick every cycle; reset mid-pulse.
    load_div(0);
    req = 4'b0001;
    pulse_run();
    seen.delete();
    repeat (5) tick();
    chk("t6_div_one", div_cur, 1);
    chk("t6_npulses", seen.size(), 5);
    chk("t6_pulse_live", tick_en, 4'b0001);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_tick_en", tick_en, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tc", tick_count, 0);
    chk("t6_rst_div", div_cur, DDIV);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1 rst = 1'b1;

    // Randomized control traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req     = N'($urandom);
      run     = ($urandom_range(0, 39) == 0);
      step    = ($urandom_range(0, 29) == 0);
      halt    = ($urandom_range(0, 49) == 0);
      cfg_we  = ($urandom_range(0, 19) == 0);
      cfg_div = CW'($urandom_range(0, 6));
      tick();
    end
    run = 1'b0; step = 1'b0; cfg_we = 1'b0;
    pulse_halt();
    repeat (3) tick();
    chk("drain_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
